horner_poly_eval: RTL and testbench

//  Iterative fixed-point polynomial evaluator, y = sum(c[k]*x^k), k = 0..N_TERMS-1, using Horner's rule.
//  One shared multiplier and one shared adder; one term per clock.

---
 rtl/horner_poly_eval.sv | 134 +++++++++++++
 tb/tb_horner_poly_eval.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/horner_poly_eval.sv
// Iterative fixed-point polynomial evaluator using Horner's rule: one shared
// multiply-add per clock, run-time writable coefficients, valid/ready on both sides.
module horner_poly_eval #(
  parameter int WIDTHIN  = 16,
  parameter int FRAC_IN  = 14,
  parameter int WIDTHOUT = 32,
  parameter int FRAC_OUT = 25,
  parameter int N_TERMS  = 6,
  parameter int SATURATE = 1,
  parameter logic [N_TERMS*WIDTHIN-1:0] COEF_INIT =
    {16'h0088, 16'h02AA, 16'h0AAA, 16'h2000, 16'h4000, 16'h4000}
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [WIDTHIN-1:0]         i_x,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [WIDTHOUT-1:0]        o_y,
  output logic                       o_ovf,
  input  logic                       cfg_we,
  input  logic [$clog2(N_TERMS)-1:0] cfg_addr,
  input  logic [WIDTHIN-1:0]         cfg_data,
  output logic                       o_cfg_ack
);

  localparam int AW = $clog2(N_TERMS);
  localparam int SH = FRAC_OUT - FRAC_IN;
  localparam int PW = WIDTHOUT + WIDTHIN;
  localparam logic [AW:0] N_TERMS_L = (AW+1)'(N_TERMS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r;
  logic [WIDTHIN-1:0]  coef_r [N_TERMS];
  logic [WIDTHOUT-1:0] acc_r;
  logic [WIDTHIN-1:0]  x_r;
  logic [AW-1:0]       cnt_r;
  logic                ovf_r;

  logic [PW-1:0]       prod_s;
  logic [WIDTHOUT-1:0] mid_s;
  logic [WIDTHOUT:0]   sum_s;
  logic                step_ovf_s;
  logic [WIDTHOUT-1:0] step_acc_s;
  logic                addr_ok_s;

  function automatic logic [WIDTHOUT-1:0] align(input logic [WIDTHIN-1:0] c);
    align = {{(WIDTHOUT-WIDTHIN){1'b0}}, c} << SH;
  endfunction

  assign o_ready   = (state_r == IDLE);
  assign addr_ok_s = ({1'b0, cfg_addr} < N_TERMS_L);

  // One Horner step: acc*x rescaled to the accumulator format, plus the next coefficient
  always_comb begin
    prod_s     = PW'(acc_r) * PW'(x_r);
    mid_s      = prod_s[FRAC_IN +: WIDTHOUT];
    sum_s      = {1'b0, mid_s} + {1'b0, align(coef_r[cnt_r])};
    step_ovf_s = (prod_s[PW-1:FRAC_IN+WIDTHOUT] != '0) | sum_s[WIDTHOUT];
    if ((SATURATE != 0) && step_ovf_s) begin
      step_acc_s = '1;
    end else begin
      step_acc_s = sum_s[WIDTHOUT-1:0];
    end
  end

  // Control FSM, datapath registers, coefficient file and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      acc_r     <= '0;
      x_r       <= '0;
      cnt_r     <= '0;
      ovf_r     <= 1'b0;
      o_valid   <= 1'b0;
      o_y       <= '0;
      o_ovf     <= 1'b0;
      o_cfg_ack <= 1'b0;
      for (int k = 0; k < N_TERMS; k++) begin
        coef_r[k] <= COEF_INIT[k*WIDTHIN +: WIDTHIN];
      end
    end else begin
      o_cfg_ack <= 1'b0;
      case (state_r)
        IDLE: begin
          // An x handshake takes priority over a same-cycle coefficient write
          if (i_valid) begin
            x_r     <= i_x;
            acc_r   <= align(coef_r[N_TERMS-1]);
            cnt_r   <= AW'(N_TERMS-2);
            ovf_r   <= 1'b0;
            state_r <= CALC;
          end else if (cfg_we && addr_ok_s) begin
            coef_r[cfg_addr] <= cfg_data;
            o_cfg_ack        <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          acc_r <= step_acc_s;
          ovf_r <= ovf_r | step_ovf_s;
          if (cnt_r == '0) begin
            state_r <= DONE;
            o_valid <= 1'b1;
            o_y     <= step_acc_s;
            o_ovf   <= ovf_r | step_ovf_s;
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state_r <= IDLE;
          end else begin
            o_valid <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_horner_poly_eval.sv
// Directed-plus-random bench for horner_poly_eval; a saturating and a wrapping
// instance share all inputs and are checked against a plain-arithmetic model.
module tb_horner_poly_eval;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic [15:0] i_x;
  logic        i_ready;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;

  logic        o_ready, o_valid, o_ovf, o_cfg_ack;
  logic [31:0] o_y;
  logic        w_ready, w_valid, w_ovf, w_cfg_ack;
  logic [31:0] w_y;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] cm [6];
  logic [95:0] def_v = {16'h0088, 16'h02AA, 16'h0AAA, 16'h2000, 16'h4000, 16'h4000};

  always #5 clk = ~clk;

  horner_poly_eval #(.SATURATE(1)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready), .i_x(i_x),
    .o_valid(o_valid), .i_ready(i_ready), .o_y(o_y), .o_ovf(o_ovf),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .o_cfg_ack(o_cfg_ack)
  );

  horner_poly_eval #(.SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(w_ready), .i_x(i_x),
    .o_valid(w_valid), .i_ready(i_ready), .o_y(w_y), .o_ovf(w_ovf),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .o_cfg_ack(w_cfg_ack)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: y = sum c[k]*x^k evaluated by Horner with the fixed-point step rules
  function automatic void model(input logic [15:0] x, input bit sat,
                                output logic [31:0] y, output bit ovf);
    longint unsigned acc, p, s;
    bit st;
    acc = 64'(cm[5]) << 11;
    ovf = 1'b0;
    for (int k = 4; k >= 0; k--) begin
      p  = acc * 64'(x);
      st = (p >> 46) != 64'd0;
      s  = ((p >> 14) & 64'hFFFF_FFFF) + (64'(cm[k]) << 11);
      if ((s >> 32) != 64'd0) st = 1'b1;
      ovf = ovf | st;
      acc = (sat && st) ? 64'hFFFF_FFFF : (s & 64'hFFFF_FFFF);
    end
    y = acc[31:0];
  endfunction

  task automatic cfg_write(input logic [2:0] addr, input logic [15:0] data);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    chk("cfg_ack", o_cfg_ack, (addr < 3'd6));
    chk("cfg_ack_wrap", w_cfg_ack, (addr < 3'd6));
    if (addr < 3'd6) cm[addr] = data;
    @(posedge clk); #1;
    chk("cfg_ack_pulse", o_cfg_ack, 1'b0);
  endtask

  // Writes are kept asserted with junk data through the whole evaluation; all must be dropped
  task automatic run_eval(input logic [15:0] x, input bit hold, output logic [31:0] ey);
    logic [31:0] ew;
    bit eo, eow;
    int lat;
    model(x, 1'b1, ey, eo);
    model(x, 1'b0, ew, eow);
    @(posedge clk); #1;
    i_valid = 1'b1; i_x = x;
    cfg_we = 1'b1; cfg_addr = 3'($urandom_range(0, 5)); cfg_data = 16'($urandom);
    if (hold) i_ready = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        i_valid = 1'b0;
        chk("accept_ready_low", o_ready, 1'b0);
      end
      chk("busy_cfg_ack", o_cfg_ack, 1'b0);
      cfg_data = 16'($urandom);
    end while (!o_valid && lat < 40);
    cfg_we = 1'b0;
    chk("latency", lat, 6);
    chk("y_sat", o_y, ey);
    chk("ovf_sat", o_ovf, eo);
    chk("valid_wrap", w_valid, 1'b1);
    chk("y_wrap", w_y, ew);
    chk("ovf_wrap", w_ovf, eow);
    if (!hold) begin
      @(posedge clk); #1;
      chk("valid_drop", o_valid, 1'b0);
      chk("ready_back", o_ready, 1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ey;
    reset = 1'b1; i_valid = 1'b0; i_x = 16'h0000; i_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 16'h0000;
    for (int k = 0; k < 6; k++) cm[k] = def_v[k*16 +: 16];
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_y", o_y, 32'h0);
    chk("rst_ovf", o_ovf, 1'b0);
    chk("rst_ack", o_cfg_ack, 1'b0);
    reset = 1'b0;

    // x=0 yields c0 alone, i.e. 1.0; x=1.0 gives the truncated Taylor e
    run_eval(16'h0000, 1'b0, ey);
    chk("t1_one", ey, 32'h0200_0000);
    run_eval(16'h4000, 1'b0, ey);
    repeat (4) run_eval(16'($urandom), 1'b0, ey);

    for (int k = 0; k < 6; k++) cfg_write(3'(k), (k == 1) ? 16'h4000 : 16'h0000);
    run_eval(16'h2000, 1'b0, ey);
    chk("t3_half", ey, 32'h0100_0000);

    cfg_write(3'd6, 16'h1111);
    cfg_write(3'd7, 16'h2222);
    run_eval(16'h2000, 1'b0, ey);

    repeat (2) begin
      for (int k = 0; k < 6; k++) cfg_write(3'(k), 16'($urandom_range(0, 16'h3FFF)));
      repeat (3) run_eval(16'($urandom_range(0, 16'h7FFF)), 1'b0, ey);
    end

    // Backpressure: result held, extra x ignored, exactly one transfer on release
    run_eval(16'h3000, 1'b1, ey);
    for (int i = 0; i < 10; i++) begin
      i_valid = 1'b1; i_x = 16'($urandom);
      @(posedge clk); #1;
      chk("bp_y", o_y, ey);
      chk("bp_valid", o_valid, 1'b1);
      chk("bp_ready", o_ready, 1'b0);
    end
    i_valid = 1'b0; i_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", o_valid, 1'b0);
    @(posedge clk); #1;
    chk("bp_single", o_valid, 1'b0);
    chk("bp_ready_back", o_ready, 1'b1);

    for (int k = 0; k < 6; k++) cfg_write(3'(k), 16'hFFFF);
    run_eval(16'hFFFF, 1'b0, ey);
    chk("t5_sat_y", ey, 32'hFFFF_FFFF);

    // Reset in the middle of CALC aborts and restores default coefficients
    @(posedge clk); #1;
    i_valid = 1'b1; i_x = 16'h4000;
    @(posedge clk); #1;
    i_valid = 1'b0;
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 16'h0000;
    @(posedge clk); #1;
    chk("calc_cfg_ack", o_cfg_ack, 1'b0);
    cfg_we = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("abort_valid", o_valid, 1'b0);
    chk("abort_ready", o_ready, 1'b1);
    chk("abort_y", o_y, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) cm[k] = def_v[k*16 +: 16];
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("abort_no_valid", o_valid, 1'b0);
    end
    run_eval(16'h4000, 1'b0, ey);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
